// File: rtl/intc_nto1_sel_pipe.sv
// Pipelined N-to-1 interrupt priority selector for a single CPU.
// A binary max-tree reduces NSRC {valid, pri, vec} leaves to one winner,
// with stage registers after every REG_STRIDE-th tree level and always at
// the output. irq_o compares the winning priority against imask_i.
// Optional feature macro: INTC_SEL_HOLD_EN (freeze pri_o/vec_o/irq_o while
// an interrupt is presented until ack_i).
module intc_nto1_sel_pipe #(
  parameter int unsigned NSRC       = 32,
  parameter int unsigned PRI_DW     = 4,
  parameter int unsigned VEC_DW     = 8,
  parameter int unsigned VEC_BASE   = 64,
  parameter int unsigned REG_STRIDE = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NSRC-1:0]          req_i,
  input  logic [NSRC*PRI_DW-1:0]   pri_i,
  input  logic [PRI_DW-1:0]        imask_i,
  input  logic                     ack_i,
  output logic                     irq_o,
  output logic [PRI_DW-1:0]        pri_o,
  output logic [VEC_DW-1:0]        vec_o,
  output logic                     valid_o
);

  localparam int unsigned LEVELS = $clog2(NSRC);
  localparam int unsigned NLEAF  = 1 << LEVELS;
  localparam int unsigned NNODE  = 2 * NLEAF - 1;
  // Heap layout: node 0 is the root, children of n are 2n+1 and 2n+2,
  // leaves occupy LEAF0 .. NNODE-1 with leaf j holding source j.
  localparam int unsigned LEAF0  = NLEAF - 1;

  // c_* is a node's combinational result, o_* the same after its optional register.
  logic [NNODE-1:0]  c_v;
  logic [NNODE-1:0]  o_v;
  logic [PRI_DW-1:0] c_p   [NNODE];
  logic [PRI_DW-1:0] o_p   [NNODE];
  logic [VEC_DW-1:0] c_vec [NNODE];
  logic [VEC_DW-1:0] o_vec [NNODE];

  for (genvar n = 0; n < NNODE; n++) begin : g_node
    localparam int unsigned Depth = $clog2(n + 2) - 1;
    localparam int unsigned Lvl   = LEVELS - Depth;

    if (n >= LEAF0) begin : g_leaf
      localparam int unsigned Src = n - LEAF0;
      if (Src < NSRC) begin : g_real
        // Only a pending source with nonzero priority competes.
        assign c_v[n]   = req_i[Src] && (pri_i[Src*PRI_DW +: PRI_DW] != '0);
        assign c_p[n]   = c_v[n] ? pri_i[Src*PRI_DW +: PRI_DW] : '0;
        assign c_vec[n] = c_v[n] ? VEC_DW'(VEC_BASE + Src) : '0;
      end else begin : g_pad
        assign c_v[n]   = 1'b0;
        assign c_p[n]   = '0;
        assign c_vec[n] = '0;
      end
    end else begin : g_cmp
      localparam int unsigned Left  = 2 * n + 1;
      localparam int unsigned Right = 2 * n + 2;
      logic take_r;
      // Invalid nodes always carry pri 0, so a strict compare both picks the
      // valid side and resolves ties toward the lower (left) index.
      assign take_r   = o_v[Right] && (o_p[Right] > o_p[Left]);
      assign c_v[n]   = o_v[Left] || o_v[Right];
      assign c_p[n]   = take_r ? o_p[Right] : o_p[Left];
      assign c_vec[n] = take_r ? o_vec[Right] : o_vec[Left];
    end

    // The root level is registered by the output stage below.
    if (Lvl > 0 && Lvl < LEVELS && (Lvl % REG_STRIDE) == 0) begin : g_reg
      logic              v_q;
      logic [PRI_DW-1:0] p_q;
      logic [VEC_DW-1:0] vec_q;

      // Mid-tree pipeline register for this node.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q   <= 1'b0;
          p_q   <= '0;
          vec_q <= '0;
        end else begin
          v_q   <= c_v[n];
          p_q   <= c_p[n];
          vec_q <= c_vec[n];
        end
      end

      assign o_v[n]   = v_q;
      assign o_p[n]   = p_q;
      assign o_vec[n] = vec_q;
    end else begin : g_pass
      assign o_v[n]   = c_v[n];
      assign o_p[n]   = c_p[n];
      assign o_vec[n] = c_vec[n];
    end
  end

  logic              valid_d, valid_q;
  logic              irq_d, irq_q;
  logic [PRI_DW-1:0] pri_d, pri_q;
  logic [VEC_DW-1:0] vec_d, vec_q;

  // Output stage next-state: root result plus mask compare, optionally held.
  always_comb begin
    valid_d = o_v[0];
    pri_d   = o_p[0];
    vec_d   = o_vec[0];
    irq_d   = o_v[0] && (o_p[0] > imask_i);
`ifdef INTC_SEL_HOLD_EN
    // The tree keeps running; only the presented interrupt is frozen.
    if (irq_q && !ack_i) begin
      pri_d = pri_q;
      vec_d = vec_q;
      irq_d = 1'b1;
    end
`endif
  end

  // Final pipeline stage driving the CPU interface.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      irq_q   <= 1'b0;
      pri_q   <= '0;
      vec_q   <= '0;
    end else begin
      valid_q <= valid_d;
      irq_q   <= irq_d;
      pri_q   <= pri_d;
      vec_q   <= vec_d;
    end
  end

`ifndef INTC_SEL_HOLD_EN
  logic unused_ack;
  assign unused_ack = ack_i;
`endif

  assign valid_o = valid_q;
  assign irq_o   = irq_q;
  assign pri_o   = pri_q;
  assign vec_o   = vec_q;

endmodule

// File: doc/intc_nto1_sel_pipe.md
Name: intc_nto1_sel_pipe

Overview:
- Parametrised, pipelined N-to-1 interrupt priority selector for one CPU; successor to the fixed 32-input combinational tree.
- Generalises source count, priority width and vector base, and inserts pipeline registers at a configurable level stride.
- Compares the winning priority against the CPU interrupt mask and raises irq_o.
- Sits between the per-source priority/pending registers and the CPU interrupt request interface.

Parameters:
- NSRC, 32, number of interrupt sources (2..64); non-power-of-2 counts are padded with non-requesting leaves.
- PRI_DW, 4, priority field width.
- VEC_DW, 8, vector field width.
- VEC_BASE, 64, vector of source 0; source i yields VEC_BASE+i (NSRC+VEC_BASE must fit VEC_DW).
- REG_STRIDE, 2, tree levels between pipeline registers (1..LEVELS); LEVELS = clog2(NSRC).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_i  in  NSRC  per-source pending request.
- pri_i  in  NSRC*PRI_DW  per-source priority, source i at [i*PRI_DW +: PRI_DW].
- imask_i  in  PRI_DW  CPU interrupt mask level.
- ack_i  in  1  CPU accepted the presented interrupt (one-cycle pulse).
- irq_o  out  1  interrupt request to CPU.
- pri_o  out  PRI_DW  winning priority.
- vec_o  out  VEC_DW  winning vector.
- valid_o  out  1  some source is requesting with nonzero priority (pipelined).

Behaviour:
- Leaf qualify: a source competes only if req_i=1 and pri_i!=0; otherwise it is treated as priority 0, not valid.
- 2:1 node: the higher priority wins. On equal priority the lower source index wins. Both invalid gives an invalid result with pri 0, vec 0.
- Pipeline registers sit after every level k where k mod REG_STRIDE = 0, and always after level LEVELS.
- Latency L = ceil(LEVELS/REG_STRIDE) cycles from req_i/pri_i to pri_o/vec_o/valid_o. NSRC=32: stride 2 gives L=3, stride 5 gives L=1.
- Each stage register carries {valid, pri, vec}. The pipeline advances every cycle with no stall.
- irq_o is registered: irq_o <= valid_o_next && (pri_next > imask_i). It is aligned with pri_o and vec_o. imask_i is sampled at the final stage only, so a mask change is seen after 1 cycle.
- Reset (asynchronous, rst_n=0): all stage registers, irq_o, pri_o, vec_o and valid_o go to 0 immediately. After rst_n rises, outputs are 0 until the first real result emerges L cycles later. Reset asserted mid-pipeline discards in-flight results.
- A request withdrawn before the output leaves the pipeline still appears for its remaining latency. The consumer must tolerate this; the feature below closes the window.
- ack_i is ignored without the optional feature.
- NSRC=2 gives LEVELS=1 and L=1.

Optional Feature:
- Macro: INTC_SEL_HOLD_EN.
- With the macro defined: once irq_o=1, pri_o, vec_o and irq_o are frozen until ack_i=1. The pipeline keeps running internally.
  - In the ack_i cycle the hold is released. The next cycle shows the current pipeline output; it is not held.
  - ack_i while irq_o=0 has no effect.
  - A higher-priority arrival during the hold does not change the outputs until after ack_i.
  - Reset clears the hold.
- Without the macro: outputs update every cycle as above.

Test Plan:
- NSRC=32, REG_STRIDE=2. Source 5 req with pri 3, imask 0 -> after exactly 3 cycles irq_o=1, pri_o=3, vec_o=69.
- Sources 7 and 20 both pri 9, source 30 pri 8, imask 2 -> vec_o=71, pri_o=9 (tie goes to the lower index).
- Source 12 pri 4, imask 4 -> valid_o=1 and irq_o=0. Then imask set to 3 -> irq_o=1 one cycle later, vec_o=76.
- req_i set with pri_i=0 on all sources -> valid_o=0, irq_o=0, vec_o=0. Then rst_n pulsed low mid-stream with source 0 pri 15 in flight -> all outputs 0 immediately, vec_o=64 only L cycles after release.
- NSRC=5, REG_STRIDE=1, VEC_BASE=16. Source 4 pri 2 -> L=3, vec_o=20. Padded leaves never win.
- With INTC_SEL_HOLD_EN: source 3 pri 5 presented (vec_o=67). Source 10 pri 12 then arrives -> outputs stay at 67 until ack_i. The cycle after ack_i -> vec_o=74, pri_o=12.
